// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, FSM states.
// The optional exception guard is enabled with the macro MDU_EXC_GUARD_EN.
package md_unit_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing {hi,lo} for mult/multu/div/divu.
// hold flags a divide by zero, in which case the controller keeps HI/LO unchanged.
module md_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hold
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_s;
  logic [31:0] div_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        b_zero;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign abs_a  = a[31] ? (~a + 32'd1) : a;
  assign abs_b  = b[31] ? (~b + 32'd1) : b;
  assign b_zero = (b == 32'd0);
  assign div_s  = b_zero ? 32'd1 : abs_b;
  assign div_u  = b_zero ? 32'd1 : b;
  assign q_mag  = abs_a / div_s;
  assign r_mag  = abs_a % div_s;
  assign q_u    = a / div_u;
  assign r_u    = a % div_u;

  always_comb begin
    hi   = 32'd0;
    lo   = 32'd0;
    hold = 1'b0;
    case (op)
      MDU_MULT:  {hi, lo} = prod_s;
      MDU_MULTU: {hi, lo} = prod_u;
      MDU_DIV: begin
        lo   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        hi   = a[31] ? (~r_mag + 32'd1) : r_mag;
        hold = b_zero;
      end
      MDU_DIVU: begin
        lo   = q_u;
        hi   = r_u;
        hold = b_zero;
      end
      default: begin
        hi   = 32'd0;
        lo   = 32'd0;
        hold = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, runs MD ops as fixed-latency operations with busy.
// Defining MDU_EXC_GUARD_EN adds the req input, which masks start while an exception is taken.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUop,
  input  logic        start,
`ifdef MDU_EXC_GUARD_EN
  input  logic        req,
`endif
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  mdu_state_e    state;
  logic [CW-1:0] counter;
  logic [31:0]   hi_n;
  logic [31:0]   lo_n;
  logic          hold_n;
  logic [31:0]   ar_hi;
  logic [31:0]   ar_lo;
  logic          ar_hold;
  logic          go;
  logic          op_mul;
  logic          op_div;

`ifdef MDU_EXC_GUARD_EN
  assign go = start & ~req;
`else
  assign go = start;
`endif

  assign op_mul = is_mul_op(MDUop);
  assign op_div = is_div_op(MDUop);

  md_arith u_arith (
    .op   (MDUop),
    .a    (A),
    .b    (B),
    .hi   (ar_hi),
    .lo   (ar_lo),
    .hold (ar_hold)
  );

  // Result is captured at launch; HI/LO only change on the final RUN edge or mthi/mtlo in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      busy    <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      hi_n    <= 32'd0;
      lo_n    <= 32'd0;
      hold_n  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go && (op_mul || op_div)) begin
            hi_n    <= ar_hi;
            lo_n    <= ar_lo;
            hold_n  <= ar_hold;
            counter <= op_mul ? MULT_N : DIV_N;
            state   <= RUN;
            busy    <= 1'b1;
          end else if (go && (MDUop == MDU_MTHI)) begin
            HI <= A;
          end else if (go && (MDUop == MDU_MTLO)) begin
            LO <= A;
          end
        end
        RUN: begin
          counter <= counter - CW'(1);
          if (counter == CW'(1)) begin
            if (!hold_n) begin
              HI <= hi_n;
              LO <= lo_n;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data = 32'd0;
    if (MDUop == MDU_MFHI)
      data = HI;
    else if (MDUop == MDU_MFLO)
      data = LO;
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed self-checking bench for md_unit_ctrl with hand-computed HI/LO results.
// Exercises the req guard as well when MDU_EXC_GUARD_EN is defined.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUop;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] data;
`ifdef MDU_EXC_GUARD_EN
  logic        req;
`endif

  int checks = 0;
  int errors = 0;

  md_unit_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUop (MDUop),
    .start (start),
`ifdef MDU_EXC_GUARD_EN
    .req   (req),
`endif
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .data  (data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDUop = op;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    MDUop = MDU_NONE;
  endtask

  task automatic waitIdle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n_exp,
                       input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int cnt;
    applyStimulus(op, a, b);
    waitIdle(cnt);
    checkOutput({tag, " busy cycles"}, 32'(cnt), 32'(n_exp));
    checkOutput({tag, " HI"}, HI, hi_exp);
    checkOutput({tag, " LO"}, LO, lo_exp);
  endtask

  task automatic readBack(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    MDUop = MDU_MFHI;
    #1 checkOutput({tag, " mfhi data"}, data, hi_exp);
    MDUop = MDU_MFLO;
    #1 checkOutput({tag, " mflo data"}, data, lo_exp);
    MDUop = MDU_NONE;
    #1 checkOutput({tag, " none data"}, data, 32'd0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    start = 1'b0;
    MDUop = MDU_NONE;
    A     = 32'd0;
    B     = 32'd0;
`ifdef MDU_EXC_GUARD_EN
    req   = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);

    runOp("mult", MDU_MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    runOp("div neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu", MDU_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    runOp("div negdiv", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

    applyStimulus(MDU_MTHI, 32'h1234, 32'd0);
    checkOutput("mthi HI", HI, 32'h1234);
    applyStimulus(MDU_MTLO, 32'h5678, 32'd0);
    checkOutput("mtlo LO", LO, 32'h5678);
    readBack("mt", 32'h1234, 32'h5678);

    runOp("div by zero", MDU_DIV, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);
    runOp("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // Launches and HI/LO writes arriving while busy must be dropped.
    applyStimulus(MDU_MULT, 32'd3, 32'd5);
    cnt   = 1;
    tick();
    $display("[TB] note: driving start while busy (pipeline should never do this)");
    start = 1'b1;
    MDUop = MDU_MTHI;
    A     = 32'hAAAA;
    cnt++;
    tick();
    MDUop = MDU_MULT;
    A     = 32'd7;
    B     = 32'd7;
    checkOutput("busy mthi ignored HI", HI, 32'd0);
    cnt++;
    tick();
    start = 1'b0;
    MDUop = MDU_NONE;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checkOutput("busy ignore cycles", 32'(cnt), 32'd5);
    checkOutput("busy ignore HI", HI, 32'd0);
    checkOutput("busy ignore LO", LO, 32'd15);
    repeat (6) tick();
    checkOutput("no relaunch busy", {31'd0, busy}, 32'd0);
    checkOutput("no relaunch LO", LO, 32'd15);

`ifdef MDU_EXC_GUARD_EN
    req = 1'b1;
    applyStimulus(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
    checkOutput("req mask busy", {31'd0, busy}, 32'd0);
    applyStimulus(MDU_MTHI, 32'hDEAD, 32'd0);
    checkOutput("req mask HI", HI, 32'd0);
    checkOutput("req mask LO", LO, 32'd15);
    req = 1'b0;
    applyStimulus(MDU_MULT, 32'd6, 32'd7);
    req = 1'b1;
    waitIdle(cnt);
    req = 1'b0;
    checkOutput("req run cycles", 32'(cnt), 32'd5);
    checkOutput("req run HI", HI, 32'd0);
    checkOutput("req run LO", LO, 32'd42);
`endif

    // Reset in the middle of a divide must abort it with no later commit.
    applyStimulus(MDU_DIVU, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort HI", HI, 32'd0);
    checkOutput("abort LO", LO, 32'd0);
    repeat (12) tick();
    checkOutput("abort late HI", HI, 32'd0);
    checkOutput("abort late LO", LO, 32'd0);
    checkOutput("abort late busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
